// File: rtl/tlb_ctrl.sv
// tlb_ctrl: fully associative single-level TLB in front of the page table walker.
//   Translates 32-bit virtual addresses using ENTRIES {valid, vpn, ppn} entries.
//   A hit responds two cycles after the request is presented. A miss issues one
//   walk, fills an entry on a valid PTE (pte[0]=1), and returns paddr or a fault.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid_i/req_ready_o/req_vaddr_i        - core request (valid/ready)
//   resp_valid_o/resp_ready_i/resp_paddr_o/resp_fault_o - core response
//   ptw_req_valid_o/ptw_req_ready_i/ptw_vaddr_o          - walk request
//   ptw_resp_valid_i/ptw_resp_ready_o/ptw_pte_i          - walk response
// Optional: define TLB_FLUSH_EN to add flush_i (clears all entries, suppresses
//   an in-flight fill while still returning that response to the core).
module tlb_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TLB_FLUSH_EN
  input  logic        flush_i,
`endif
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_paddr_o,
  output logic        resp_fault_o,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_PTW_REQ  = 3'd2,
    S_PTW_WAIT = 3'd3,
    S_RESPOND  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          vaddr_q, vaddr_d;
  logic [31:0]          paddr_q, paddr_d;
  logic                 fault_q, fault_d;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [19:0]          vpn_q [ENTRIES];
  logic [19:0]          vpn_d [ENTRIES];
  logic [19:0]          ppn_q [ENTRIES];
  logic [19:0]          ppn_d [ENTRIES];
  logic [IDX_W-1:0]     rptr_q, rptr_d;
  logic                 drop_fill_q, drop_fill_d;

  logic                 flush;
`ifdef TLB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // PTE bits outside the PPN and valid bit carry no meaning here.
  logic unused_pte_bits;
  assign unused_pte_bits = ^{ptw_pte_i[31:30], ptw_pte_i[9:1]};

  // Associative match; at most one entry can match since fills never duplicate a VPN.
  logic        hit;
  logic [19:0] hit_ppn;
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == vaddr_q[31:12])) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ppn_q[i];
      end
    end
  end

  // Victim: lowest-index invalid entry, else the round-robin pointer.
  logic             have_inv;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] victim;
  always_comb begin
    have_inv = 1'b0;
    inv_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_inv = 1'b1;
        inv_idx  = IDX_W'(i);
      end
    end
    victim = have_inv ? inv_idx : rptr_q;
  end

  logic ptw_resp_fire;
  assign ptw_resp_fire = (state_q == S_PTW_WAIT) && ptw_resp_valid_i;

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vaddr_q     <= '0;
      paddr_q     <= '0;
      fault_q     <= 1'b0;
      valid_q     <= '0;
      rptr_q      <= '0;
      drop_fill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      paddr_q     <= paddr_d;
      fault_q     <= fault_d;
      valid_q     <= valid_d;
      rptr_q      <= rptr_d;
      drop_fill_q <= drop_fill_d;
    end
  end

  // Entry payload needs no reset: it is only observed through valid_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      vpn_q[i] <= vpn_d[i];
      ppn_q[i] <= ppn_d[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid_i)      state_d = S_LOOKUP;
      S_LOOKUP:   state_d = (hit && !flush) ? S_RESPOND : S_PTW_REQ;
      S_PTW_REQ:  if (ptw_req_ready_i)  state_d = S_PTW_WAIT;
      S_PTW_WAIT: if (ptw_resp_valid_i) state_d = S_RESPOND;
      S_RESPOND:  if (resp_ready_i)     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath next values: request capture, result capture, fill, flush.
  always_comb begin
    vaddr_d     = vaddr_q;
    paddr_d     = paddr_q;
    fault_d     = fault_q;
    valid_d     = valid_q;
    rptr_d      = rptr_q;
    drop_fill_d = drop_fill_q;
    for (int i = 0; i < ENTRIES; i++) begin
      vpn_d[i] = vpn_q[i];
      ppn_d[i] = ppn_q[i];
    end

    case (state_q)
      S_IDLE: begin
        drop_fill_d = 1'b0;
        if (req_valid_i) vaddr_d = req_vaddr_i;
      end
      S_LOOKUP: begin
        if (hit && !flush) begin
          paddr_d = {hit_ppn, vaddr_q[11:0]};
          fault_d = 1'b0;
        end
      end
      S_PTW_WAIT: begin
        if (ptw_resp_fire) begin
          if (!ptw_pte_i[0]) begin
            paddr_d = '0;
            fault_d = 1'b1;
          end else begin
            paddr_d = {ptw_pte_i[29:10], vaddr_q[11:0]};
            fault_d = 1'b0;
            if (!drop_fill_q && !flush) begin
              valid_d[victim] = 1'b1;
              vpn_d[victim]   = vaddr_q[31:12];
              ppn_d[victim]   = ptw_pte_i[29:10];
              if (!have_inv) rptr_d = rptr_q + 1'b1;
            end
          end
        end
      end
      S_PTW_REQ, S_RESPOND: ;
      default: begin
        vaddr_d     = '0;
        paddr_d     = '0;
        fault_d     = 1'b0;
        drop_fill_d = 1'b0;
      end
    endcase

    // A flush while a walk is outstanding makes its PTE stale for filling.
    if (flush) begin
      valid_d = '0;
      rptr_d  = '0;
      if ((state_q == S_PTW_REQ) || ((state_q == S_PTW_WAIT) && !ptw_resp_fire))
        drop_fill_d = 1'b1;
    end
  end

  // Output decode, purely from registered state.
  always_comb begin
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    resp_paddr_o     = '0;
    resp_fault_o     = 1'b0;
    ptw_req_valid_o  = 1'b0;
    ptw_vaddr_o      = '0;
    ptw_resp_ready_o = 1'b0;
    case (state_q)
      S_IDLE:     req_ready_o = 1'b1;
      S_LOOKUP:   ;
      S_PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_vaddr_o     = vaddr_q;
      end
      S_PTW_WAIT: ptw_resp_ready_o = 1'b1;
      S_RESPOND: begin
        resp_valid_o = 1'b1;
        resp_paddr_o = paddr_q;
        resp_fault_o = fault_q;
      end
      default:    req_ready_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
module tb_tlb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_paddr_o;
  logic        resp_fault_o;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i = 1'b0;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i = 1'b0;
  logic        ptw_resp_ready_o;
  logic [31:0] ptw_pte_i = '0;
`ifdef TLB_FLUSH_EN
  logic        flush_i = 1'b0;
`endif

  always #5 clk = ~clk;

  tlb_ctrl #(.ENTRIES(8), .IDX_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef TLB_FLUSH_EN
    .flush_i          (flush_i),
`endif
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vaddr_i      (req_vaddr_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_paddr_o     (resp_paddr_o),
    .resp_fault_o     (resp_fault_o),
    .ptw_req_valid_o  (ptw_req_valid_o),
    .ptw_req_ready_i  (ptw_req_ready_i),
    .ptw_vaddr_o      (ptw_vaddr_o),
    .ptw_resp_valid_i (ptw_resp_valid_i),
    .ptw_resp_ready_o (ptw_resp_ready_o),
    .ptw_pte_i        (ptw_pte_i)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"},      32'(req_ready_o),      32'd1);
    chk({tag, ".resp_valid"},     32'(resp_valid_o),     32'd0);
    chk({tag, ".resp_paddr"},     resp_paddr_o,          32'd0);
    chk({tag, ".resp_fault"},     32'(resp_fault_o),     32'd0);
    chk({tag, ".ptw_req_valid"},  32'(ptw_req_valid_o),  32'd0);
    chk({tag, ".ptw_vaddr"},      ptw_vaddr_o,           32'd0);
    chk({tag, ".ptw_resp_ready"}, 32'(ptw_resp_ready_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One translation, driven and observed at negedges. The bench acts as the
  // walker (answering pte as soon as the TLB is ready) and as the core.
  task automatic translate(input string tag, input logic [31:0] va, input logic [31:0] pte,
                           input logic [31:0] exp_paddr, input logic exp_fault,
                           input int exp_walks, input int ptw_stall, input int resp_stall,
                           input bit chk_lat);
    exp_t e;
    int   walks = 0;
    int   pst = 0;
    int   rs = 0;
    int   lat = 0;
    bit   done = 1'b0;
    e.paddr = exp_paddr;
    e.fault = exp_fault;
    chk({tag, ".req_ready_idle"}, 32'(req_ready_o), 32'd1);
    sb.push_back(e);
    req_valid_i = 1'b1;
    req_vaddr_i = va;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c == 1) req_valid_i = 1'b0;
      if (ptw_req_valid_o) begin
        chk({tag, ".ptw_vaddr"}, ptw_vaddr_o, va);
        if (pst < ptw_stall) begin
          ptw_req_ready_i = 1'b0;
          pst++;
        end else begin
          ptw_req_ready_i = 1'b1;
          walks++;
        end
      end else begin
        ptw_req_ready_i = 1'b0;
      end
      ptw_resp_valid_i = ptw_resp_ready_o;
      ptw_pte_i        = pte;
      if (resp_valid_o) begin
        if (lat == 0) lat = c;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (rs < resp_stall) begin
          resp_ready_i = 1'b0;
          rs++;
          chk({tag, ".stall_paddr"},  resp_paddr_o,        sb[0].paddr);
          chk({tag, ".stall_fault"},  32'(resp_fault_o),   32'(sb[0].fault));
          chk({tag, ".stall_rdy_lo"}, 32'(req_ready_o),    32'd0);
        end else begin
          resp_ready_i = 1'b1;
          e = sb.pop_front();
          chk({tag, ".paddr"}, resp_paddr_o,      e.paddr);
          chk({tag, ".fault"}, 32'(resp_fault_o), 32'(e.fault));
          done = 1'b1;
        end
      end else begin
        resp_ready_i = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready_i     = 1'b0;
    ptw_req_ready_i  = 1'b0;
    ptw_resp_valid_i = 1'b0;
    chk({tag, ".completed"}, 32'(done), 32'd1);
    chk({tag, ".walks"}, 32'(walks), 32'(exp_walks));
    if (ptw_stall > 0) chk({tag, ".ptw_stalls"}, 32'(pst), 32'(ptw_stall));
    if (resp_stall > 0) chk({tag, ".resp_stalls"}, 32'(rs), 32'(resp_stall));
    if (chk_lat) chk({tag, ".hit_latency"}, 32'(lat), 32'd2);
    if (!done) sb.delete();
  endtask

  initial begin
    bit got_wait;
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then hit on the filled page.
    translate("cold_miss", 32'h00401ABC, 32'h00004401, 32'h00011ABC, 1'b0, 1, 0, 0, 1'b0);
    translate("hit_after_fill", 32'h00401004, 32'h0, 32'h00011004, 1'b0, 0, 0, 0, 1'b1);

    // Faulting PTE: no fill, so the repeat walks again.
    translate("fault1", 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    translate("fault2", 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    translate("fault_odd_pte", 32'h90000000, 32'h3FFFFC00, 32'h0, 1'b1, 1, 0, 0, 1'b0);

    // Backpressure on both the walk request and the core response.
    translate("backpressure", 32'h00402123, 32'h00008801, 32'h00022123, 1'b0, 1, 4, 5, 1'b0);
    translate("bp_hit", 32'h00402FFF, 32'h0, 32'h00022FFF, 1'b0, 0, 0, 5, 1'b1);

    // Reset while waiting on the walker.
    chk("mw.req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_vaddr_i = 32'h00403123;
    @(negedge clk);
    req_valid_i = 1'b0;
    got_wait = 1'b0;
    for (int c = 0; c < 20 && !got_wait; c++) begin
      ptw_req_ready_i = ptw_req_valid_o;
      if (ptw_resp_ready_o) got_wait = 1'b1;
      else @(negedge clk);
    end
    ptw_req_ready_i = 1'b0;
    chk("mw.reached_wait", 32'(got_wait), 32'd1);
    rst = 1'b1;
    ptw_resp_valid_i = 1'b1;
    ptw_pte_i = 32'h0000C001;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mw_after_rst");
    @(negedge clk);
    chk("mw.late_resp_ignored", 32'(ptw_resp_ready_o), 32'd0);
    chk("mw.no_resp", 32'(resp_valid_o), 32'd0);
    ptw_resp_valid_i = 1'b0;
    translate("post_rst_miss", 32'h00401ABC, 32'h00004401, 32'h00011ABC, 1'b0, 1, 0, 0, 1'b0);

    // Replacement: fill vpn 0..7, then vpn 8 evicts entry 0.
    do_reset();
    for (int i = 0; i < 8; i++)
      translate($sformatf("fill_vpn%0d", i), {20'(i), 12'h0A4}, (32'(32'h100 + i) << 10) | 32'd1,
                {20'(32'h100 + i), 12'h0A4}, 1'b0, 1, 0, 0, 1'b0);
    translate("fill_vpn8", {20'd8, 12'h0A4}, (32'h108 << 10) | 32'd1,
              {20'h00108, 12'h0A4}, 1'b0, 1, 0, 0, 1'b0);
    for (int i = 1; i < 8; i++)
      translate($sformatf("hit_vpn%0d", i), {20'(i), 12'h0A4}, 32'h0,
                {20'(32'h100 + i), 12'h0A4}, 1'b0, 0, 0, 0, 1'b1);
    translate("evicted_vpn0", {20'd0, 12'h0A4}, (32'h200 << 10) | 32'd1,
              {20'h00200, 12'h0A4}, 1'b0, 1, 0, 0, 1'b0);
    translate("hit_vpn8", {20'd8, 12'h0A4}, 32'h0, {20'h00108, 12'h0A4}, 1'b0, 0, 0, 0, 1'b1);
    translate("evicted_vpn1", {20'd1, 12'h0A4}, (32'h201 << 10) | 32'd1,
              {20'h00201, 12'h0A4}, 1'b0, 1, 0, 0, 1'b0);
    translate("hit_vpn0_new", {20'd0, 12'h0A4}, 32'h0, {20'h00200, 12'h0A4}, 1'b0, 0, 0, 0, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Fully associative, single-level instruction/data TLB that sits directly upstream of the page table walker.
- Accepts 32-bit virtual addresses from the core and translates hits from its entry array.
- On a miss, issues one walk request over the PTW valid/ready interface and consumes the returned PTE (zero PTE = invalid).
- Fills the array on a valid PTE and returns a physical address or fault to the core.

Parameters:
ENTRIES, 8, number of TLB entries; power of two, >= 2
IDX_W, 3, log2(ENTRIES); entry index / replacement pointer width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid_i  input  1  core translation request valid
req_ready_o  output  1  TLB can accept a request
req_vaddr_i  input  32  virtual address
resp_valid_o  output  1  translation result valid
resp_ready_i  input  1  core accepts result
resp_paddr_o  output  32  physical address (0 on fault)
resp_fault_o  output  1  page fault (invalid PTE)
ptw_req_valid_o  output  1  walk request valid
ptw_req_ready_i  input  1  walker ready
ptw_vaddr_o  output  32  address to walk
ptw_resp_valid_i  input  1  walker response valid
ptw_resp_ready_o  output  1  TLB accepts walker response
ptw_pte_i  input  32  leaf PTE; 0 means invalid

Behaviour:
- Entry contents: valid bit, vpn[19:0] (= vaddr[31:12]), ppn[19:0] (= pte[29:10]).
- Translation: paddr = {ppn, vaddr[11:0]}.
- Reset values: req_ready_o=1; all other outputs 0; all valid bits 0; replacement pointer 0; state IDLE. A reset asserted mid-operation aborts any walk and drops any pending response.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o:
  - Register vaddr.
  - Drop req_ready_o.
  - Next state LOOKUP.
- LOOKUP (1 cycle): compare the registered vpn against all valid entries.
  - Hit: register paddr, fault=0, assert resp_valid_o, go to RESPOND. The response is valid 2 cycles after the accept edge.
  - Miss: set ptw_vaddr_o=vaddr, assert ptw_req_valid_o, go to PTW_REQ.
- PTW_REQ: hold ptw_req_valid_o and ptw_vaddr_o stable until ptw_req_ready_i.
  - On handshake, deassert ptw_req_valid_o, assert ptw_resp_ready_o, go to PTW_WAIT.
- PTW_WAIT: on ptw_resp_valid_i&&ptw_resp_ready_o, deassert ptw_resp_ready_o and go to RESPOND.
  - pte[0]==0 (includes pte==0): resp_fault_o=1, resp_paddr_o=0, no fill.
  - Otherwise: resp_fault_o=0, resp_paddr_o={pte[29:10], vaddr[11:0]}, and fill one entry.
- Fill victim selection:
  - Use the lowest-index invalid entry if one exists.
  - Otherwise use the replacement pointer, which then increments modulo ENTRIES.
  - The pointer is unchanged when an invalid slot is used.
- Duplicate fills: a VPN cannot already be present at fill time (single outstanding request), so no duplicate check is needed.
- RESPOND: hold resp_valid_o, resp_paddr_o and resp_fault_o stable until resp_ready_i.
  - On handshake, clear resp_valid_o, set req_ready_o=1, go to IDLE.
  - The next request can be accepted 1 cycle after the response handshake.
- Concurrency and ordering:
  - Only one request is in flight; no hit-under-miss.
  - Fill is visible to a lookup starting the cycle after the fill edge.
- Unknown state encodings return to IDLE with outputs at their reset values.

Optional Feature:
TLB_FLUSH_EN: adds input flush_i (1 bit).
- Clears all valid bits on the next edge and resets the replacement pointer to 0.
- In LOOKUP, flush takes priority: the lookup is treated as a miss.
- In PTW_WAIT, or in the response cycle itself, the pending fill is suppressed but the response is still returned to the core.
- Without the macro: no port, and entries are invalidated only by rst.

Test Plan:
- Cold miss: vaddr 0x00401ABC, walker returns pte 0x00004401 -> ptw_vaddr_o=0x00401ABC; resp_paddr_o=0x00011ABC; fault=0; entry 0 valid.
- Hit after fill: vaddr 0x00401004 -> no ptw_req_valid_o pulse; resp_paddr_o=0x00011004; resp_valid_o 2 cycles after accept.
- Fault: vaddr 0x80000000, pte 0x00000000 -> resp_fault_o=1, paddr 0, no fill. Repeating the same vaddr issues a second walk.
- Replacement, ENTRIES=8: fill vpn 0..7, then vpn 8.
  - vpn 8 replaces entry 0; pointer becomes 1.
  - Vpn 0 then misses (walk issued); vpn 1 hits.
- Backpressure:
  - resp_ready_i low 5 cycles -> resp_valid_o/paddr/fault stable, req_ready_o=0.
  - ptw_req_ready_i low 4 cycles -> ptw_req_valid_o/vaddr stable.
- Reset mid-walk: assert rst in PTW_WAIT -> next cycle req_ready_o=1, all else 0. The late ptw response is ignored (ptw_resp_ready_o=0), and the previously filled vaddr misses.
